wb_trace_checker: RTL and testbench

- Synthesizable writeback-trace checker for the openMIPS min SOPC bench.
- Replaces cycle-timed per-register assertions with order-based checking.
- Expected writes (channel, address, data, don't-care mask) are preloaded into per-channel FIFOs. The CPU's writeback ports are then checked in order, independent of pipeline stalls or branch-delay timing.
- Reports pass/fail/timeout, match and mismatch counters, and a capture of the first error.

---
 rtl/wb_trace_checker_pkg.sv | 29 ++
 rtl/wtc_fifo.sv | 60 ++++++
 rtl/wb_trace_checker.sv | 231 +++++++++++++++++++++++
 tb/tb_wb_trace_checker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_checker_pkg.sv
// Shared definitions for the writeback-trace checker: state encodings,
// default parameters and width helpers for the FIFO entry layout.
package wb_trace_checker_pkg;

    localparam int WTC_NUM_CH  = 2;
    localparam int WTC_DW      = 32;
    localparam int WTC_AW      = 5;
    localparam int WTC_DEPTH   = 64;
    localparam int WTC_TIMEOUT = 256;
    localparam int WTC_CW      = 16;

    typedef enum logic [2:0] {
        WTC_IDLE = 3'd0,
        WTC_LOAD = 3'd1,
        WTC_RUN  = 3'd2,
        WTC_PASS = 3'd3,
        WTC_FAIL = 3'd4
    } wtc_state_e;

    // Expected entry is packed as {mask, data, addr}, addr in the LSBs.
    function automatic int wtc_entry_w(input int dw, input int aw);
        return 2 * dw + aw;
    endfunction

    function automatic int wtc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/wtc_fifo.sv
// Single-clock FIFO with first-word-fall-through head, synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module wtc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign full   = (r_count == CNTW'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; r_count alone decides which words are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Order-based writeback checker: expected writes are preloaded per channel and
// consumed in order by the CPU's writeback strobes, independent of timing.
module wb_trace_checker
    import wb_trace_checker_pkg::*;
#(
    parameter int NUM_CH  = WTC_NUM_CH,
    parameter int DW      = WTC_DW,
    parameter int AW      = WTC_AW,
    parameter int DEPTH   = WTC_DEPTH,
    parameter int TIMEOUT = WTC_TIMEOUT,
    parameter int CW      = WTC_CW,
    localparam int CHW    = wtc_ch_w(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [CHW-1:0]       load_ch,
    input  logic [AW-1:0]        load_addr,
    input  logic [DW-1:0]        load_data,
    input  logic [DW-1:0]        load_mask,
    input  logic [NUM_CH-1:0]    wb_valid,
    input  logic [NUM_CH*AW-1:0] wb_addr,
    input  logic [NUM_CH*DW-1:0] wb_data,
    output logic [2:0]           state,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [CW-1:0]        match_cnt,
    output logic [CW-1:0]        mismatch_cnt,
    output logic [CHW-1:0]       err_ch,
    output logic [AW-1:0]        err_addr,
    output logic [DW-1:0]        err_data,
    output logic [DW-1:0]        err_exp
);

    localparam int EW  = wtc_entry_w(DW, AW);
    localparam int IW  = $clog2(TIMEOUT + 1);
    localparam int PCW = $clog2(NUM_CH + 1);

    typedef struct packed {
        logic [DW-1:0] mask;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } entry_t;

    wtc_state_e       r_state;
    logic             r_pass, r_fail, r_timeout, r_err_valid;
    logic [CW-1:0]    r_match_cnt, r_mismatch_cnt;
    logic [IW-1:0]    r_idle;
    logic [CHW-1:0]   r_err_ch;
    logic [AW-1:0]    r_err_addr;
    logic [DW-1:0]    r_err_data, r_err_exp;

    entry_t           w_load_entry;
    entry_t           w_head [NUM_CH];
    logic [NUM_CH-1:0] w_full, w_empty, w_push, w_pop, w_match, w_mis;
    logic             w_ch_ok, w_sel_full, w_load_acc, w_monitor, w_clear;
    logic             w_all_empty, w_any_mis, w_any_wb;
    logic [PCW-1:0]   w_n_match, w_n_mis;
    logic [CHW-1:0]   w_err_ch;
    logic [AW-1:0]    w_err_addr;
    logic [DW-1:0]    w_err_data, w_err_exp;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [PCW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + (CW+1)'(b);
        return s[CW] ? '1 : s[CW-1:0];
    endfunction

    assign w_load_entry = '{mask: load_mask, data: load_data, addr: load_addr};
    assign w_monitor    = (r_state == WTC_RUN) || (r_state == WTC_PASS) || (r_state == WTC_FAIL);
    assign w_clear      = start && ((r_state == WTC_PASS) || (r_state == WTC_FAIL));
    assign w_all_empty  = &w_empty;
    assign w_any_mis    = |w_mis;
    assign w_any_wb     = |wb_valid;
    assign w_load_acc   = load_valid & load_ready;

    // Channel decode by comparison so out-of-range codes simply never match.
    always_comb begin
        // NOTE: defaults first so no path through the block infers a latch.
        w_ch_ok    = 1'b0;
        w_sel_full = 1'b1;
        w_push     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (load_ch == CHW'(c)) begin
                w_ch_ok    = 1'b1;
                w_sel_full = w_full[c];
                w_push[c]  = w_load_acc;
            end
        end
        load_ready = rst && ((r_state == WTC_IDLE) || (r_state == WTC_LOAD)) && w_ch_ok && !w_sel_full;
    end

    always_comb begin
        w_match    = '0;
        w_mis      = '0;
        w_pop      = '0;
        w_n_match  = '0;
        w_n_mis    = '0;
        w_err_ch   = '0;
        w_err_addr = '0;
        w_err_data = '0;
        w_err_exp  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_monitor && wb_valid[c]) begin
                w_pop[c]   = !w_empty[c];
                w_match[c] = !w_empty[c]
                           && (wb_addr[c*AW +: AW] == w_head[c].addr)
                           && (((wb_data[c*DW +: DW] ^ w_head[c].data) & w_head[c].mask) == '0);
                w_mis[c]   = !w_match[c];
            end
            w_n_match = w_n_match + PCW'(w_match[c]);
            w_n_mis   = w_n_mis + PCW'(w_mis[c]);
        end
        // Descending scan leaves the lowest failing channel selected.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_mis[c]) begin
                w_err_ch   = CHW'(c);
                w_err_addr = wb_addr[c*AW +: AW];
                w_err_data = wb_data[c*DW +: DW];
                w_err_exp  = w_empty[c] ? '0 : w_head[c].data;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        wtc_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[g]),
            .pop   (w_pop[g]),
            .flush (w_clear),
            .din   (w_load_entry),
            .full  (w_full[g]),
            .empty (w_empty[g]),
            .head  (w_head[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= WTC_IDLE;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_timeout      <= 1'b0;
            r_err_valid    <= 1'b0;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_idle         <= '0;
            r_err_ch       <= '0;
            r_err_addr     <= '0;
            r_err_data     <= '0;
            r_err_exp      <= '0;
        end else if (w_clear) begin
            r_state        <= WTC_IDLE;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_timeout      <= 1'b0;
            r_err_valid    <= 1'b0;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_idle         <= '0;
            r_err_ch       <= '0;
            r_err_addr     <= '0;
            r_err_data     <= '0;
            r_err_exp      <= '0;
        end else begin
            case (r_state)
                WTC_IDLE, WTC_LOAD: begin
                    r_idle <= '0;
                    if (start)           r_state <= WTC_RUN;
                    else if (w_load_acc) r_state <= WTC_LOAD;
                end
                WTC_RUN: begin
                    if (w_all_empty) begin
                        if ((r_mismatch_cnt == '0) && !w_any_mis) begin
                            r_state <= WTC_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= WTC_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end else if (w_any_wb) begin
                        r_idle <= '0;
                    end else if (r_idle == IW'(TIMEOUT - 1)) begin
                        r_state   <= WTC_FAIL;
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                WTC_PASS: begin
                    if (w_any_wb) begin
                        r_state <= WTC_FAIL;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b1;
                    end
                end
                WTC_FAIL: r_state <= WTC_FAIL;
                default:  r_state <= WTC_IDLE;
            endcase

            if (w_monitor) begin
                r_match_cnt    <= sat_add(r_match_cnt, w_n_match);
                r_mismatch_cnt <= sat_add(r_mismatch_cnt, w_n_mis);
                if (!r_err_valid && w_any_mis) begin
                    r_err_valid <= 1'b1;
                    r_err_ch    <= w_err_ch;
                    r_err_addr  <= w_err_addr;
                    r_err_data  <= w_err_data;
                    r_err_exp   <= w_err_exp;
                end
            end
        end
    end

    assign state        = r_state;
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign timeout      = r_timeout;
    assign match_cnt    = r_match_cnt;
    assign mismatch_cnt = r_mismatch_cnt;
    assign err_ch       = r_err_ch;
    assign err_addr     = r_err_addr;
    assign err_data     = r_err_data;
    assign err_exp      = r_err_exp;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: jump trace, mismatch, mask, dual-channel,
// back-pressure/timeout and asynchronous reset scenarios.
module tb_wb_trace_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        load_valid;
    logic        load_ready;
    logic [0:0]  load_ch;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] load_mask;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_addr;
    logic [63:0] wb_data;
    logic [2:0]  state;
    logic        pass, fail, timeout;
    logic [15:0] match_cnt, mismatch_cnt;
    logic [0:0]  err_ch;
    logic [4:0]  err_addr;
    logic [31:0] err_data, err_exp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_trace_checker dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_ch      (load_ch),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_mask    (load_mask),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .state        (state),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .match_cnt    (match_cnt),
        .mismatch_cnt (mismatch_cnt),
        .err_ch       (err_ch),
        .err_addr     (err_addr),
        .err_data     (err_data),
        .err_exp      (err_exp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input logic ch, input logic [4:0] addr,
                              input logic [31:0] data, input logic [31:0] mask);
        load_ch    = ch;
        load_addr  = addr;
        load_data  = data;
        load_mask  = mask;
        load_valid = 1'b1;
        #1;
        check("load_ready", load_ready, 1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                            input logic [4:0] a1, input logic [31:0] d1);
        wb_valid = v;
        wb_addr  = {a1, a0};
        wb_data  = {d1, d0};
        tick();
        wb_valid = 2'b00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
        for (int i = 0; i < budget && state != target; i++) tick();
        check(tag, state, target);
    endtask

    logic [4:0]  j_addr [11] = '{5'd1, 5'd1, 5'd1, 5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
    logic [31:0] j_data [11] = '{32'h1, 32'h2, 32'h3, 32'h2C, 32'h48, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA};

    initial begin
        #1ms;
        $display("FAIL watchdog: got=expired exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        load_valid = 1'b1;
        load_ch    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_mask  = '0;
        wb_valid   = '0;
        wb_addr    = '0;
        wb_data    = '0;
        #3;
        check("rst_load_ready", load_ready, 0);
        check("rst_state", state, 0);
        check("rst_flags", {pass, fail, timeout}, 0);
        check("rst_cnts", {match_cnt, mismatch_cnt}, 0);
        load_valid = 1'b0;
        #10 rst = 1'b1;
        tick();

        // Jump-sequence trace with random gaps and interleaved HI/LO writes.
        for (int i = 0; i < 11; i++) load_entry(1'b0, j_addr[i], j_data[i], 32'hFFFF_FFFF);
        load_entry(1'b1, 5'd0, 32'h2, 32'hFFFF_FFFF);
        load_entry(1'b1, 5'd1, 32'hE, 32'hFFFF_FFFF);
        check("jump_load_state", state, 1);
        pulse_start();
        check("jump_run_state", state, 2);
        for (int i = 0; i < 11; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            if (i == 7) begin
                wb_write(2'b10, 5'd0, 32'h0, 5'd1, 32'hE);
                repeat ($urandom_range(0, 5)) tick();
            end
            if (i == 3) wb_write(2'b11, j_addr[i], j_data[i], 5'd0, 32'h2);
            else        wb_write(2'b01, j_addr[i], j_data[i], 5'd0, 32'h0);
        end
        check("jump_still_run", state, 2);
        tick();
        check("jump_pass_state", state, 3);
        check("jump_pass_flag", pass, 1);
        check("jump_match_cnt", match_cnt, 13);
        check("jump_mismatch_cnt", mismatch_cnt, 0);

        // A write in PASS is unexpected and flips the result to FAIL.
        wb_write(2'b01, 5'd5, 32'h1, 5'd0, 32'h0);
        check("pass_wr_state", state, 4);
        check("pass_wr_flags", {pass, fail}, 2'b01);
        check("pass_wr_mis", mismatch_cnt, 1);
        check("pass_wr_err", {err_addr, err_exp}, {5'd5, 32'h0});
        pulse_start();
        check("clear_state", state, 0);
        check("clear_cnts", {match_cnt, mismatch_cnt}, 0);
        check("clear_flags", {pass, fail, timeout}, 0);

        // Data mismatch.
        load_entry(1'b0, 5'd1, 32'h3, 32'hFFFF_FFFF);
        pulse_start();
        wb_write(2'b01, 5'd1, 32'h4, 5'd0, 32'h0);
        wait_state("mis_state", 3'd4, 3);
        check("mis_fail", fail, 1);
        check("mis_cnt", mismatch_cnt, 1);
        check("mis_err_ch", err_ch, 0);
        check("mis_err_addr", err_addr, 1);
        check("mis_err_data", err_data, 4);
        check("mis_err_exp", err_exp, 3);
        wb_write(2'b01, 5'd9, 32'h9, 5'd0, 32'h0);
        check("mis_sticky_cnt", mismatch_cnt, 2);
        check("mis_sticky_err", err_data, 4);
        check("mis_sticky_state", state, 4);
        pulse_start();

        // Don't-care masks, masked-bit mismatch and address mismatch.
        load_entry(1'b0, 5'd31, 32'h0, 32'h0);
        load_entry(1'b0, 5'd5, 32'h1234_0000, 32'hFFFF_0000);
        load_entry(1'b0, 5'd6, 32'h1234_0000, 32'hFFFF_0000);
        load_entry(1'b0, 5'd7, 32'h1, 32'hFFFF_FFFF);
        pulse_start();
        wb_write(2'b01, 5'd31, 32'hDEAD_BEEF, 5'd0, 32'h0);
        wb_write(2'b01, 5'd5, 32'h1234_5678, 5'd0, 32'h0);
        check("mask_match_cnt", match_cnt, 2);
        check("mask_mis_none", mismatch_cnt, 0);
        wb_write(2'b01, 5'd6, 32'h1235_0000, 5'd0, 32'h0);
        wb_write(2'b01, 5'd8, 32'h1, 5'd0, 32'h0);
        check("mask_mis_cnt", mismatch_cnt, 2);
        check("mask_err", {err_addr, err_data, err_exp}, {5'd6, 32'h1235_0000, 32'h1234_0000});
        wait_state("mask_state", 3'd4, 3);
        pulse_start();

        // Simultaneous channels, then an unexpected write on ch1.
        load_entry(1'b0, 5'd2, 32'h55, 32'hFFFF_FFFF);
        load_entry(1'b0, 5'd3, 32'h66, 32'hFFFF_FFFF);
        load_entry(1'b1, 5'd1, 32'h99, 32'hFFFF_FFFF);
        pulse_start();
        wb_write(2'b11, 5'd2, 32'h55, 5'd1, 32'h99);
        check("sim_match2", match_cnt, 2);
        wb_write(2'b11, 5'd3, 32'h66, 5'd0, 32'h77);
        check("sim_match3", match_cnt, 3);
        check("sim_mis1", mismatch_cnt, 1);
        check("sim_err", {err_ch, err_addr, err_data, err_exp}, {1'b1, 5'd0, 32'h77, 32'h0});
        wait_state("sim_state", 3'd4, 3);
        pulse_start();

        // Back-pressure on a full FIFO, then timeout.
        for (int i = 0; i < 64; i++) load_entry(1'b0, 5'(i), 32'(i), 32'hFFFF_FFFF);
        load_valid = 1'b1;
        load_ch    = 1'b0;
        #1;
        check("bp_full_ready", load_ready, 0);
        load_ch = 1'b1;
        #1;
        check("bp_other_ready", load_ready, 1);
        load_valid = 1'b0;
        pulse_start();
        repeat (200) tick();
        check("to_not_yet", {timeout, state}, {1'b0, 3'd2});
        wait_state("to_state", 3'd4, 100);
        check("to_flags", {timeout, fail, pass}, 3'b110);
        check("to_no_mis", mismatch_cnt, 0);
        pulse_start();
        check("to_clear", {state, timeout, fail}, 0);
        pulse_start();
        tick();
        check("to_flushed_pass", state, 3);
        pulse_start();

        // Asynchronous reset between clock edges in the middle of a run.
        for (int i = 0; i < 4; i++) load_entry(1'b0, 5'd1, 32'h10 + 32'(i), 32'hFFFF_FFFF);
        pulse_start();
        wb_write(2'b01, 5'd1, 32'h10, 5'd0, 32'h0);
        wb_write(2'b01, 5'd1, 32'h11, 5'd0, 32'h0);
        check("rr_match", match_cnt, 2);
        #2 rst = 1'b0;
        #1;
        check("rr_state", state, 0);
        check("rr_cnt", match_cnt, 0);
        check("rr_ready", load_ready, 0);
        #2 rst = 1'b1;
        tick();
        pulse_start();
        check("rr_run", state, 2);
        tick();
        check("rr_empty_pass", state, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
